// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite timer: response codes, register map, bus FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_STATUS   = 3'd1,
        REG_COUNT    = 3'd2,
        REG_COMPARE  = 3'd3,
        REG_PRESCALE = 3'd4,
        REG_SCRATCH  = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_off_e;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axil_timer_slave_timer_core.sv
// Prescaled 32-bit up-counter with compare match and optional auto-reload.
// Latency: count/match update one cycle after a tick or a load strobe.
// Backpressure: none; loads and clears are single-cycle strobes that always take effect.
module timer_core #(
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             autoreload,
    input  logic [PRE_W-1:0] prescale,
    input  logic             prescale_clr,
    input  logic [31:0]      compare,
    input  logic             count_ld,
    input  logic [31:0]      count_ld_val,
    input  logic             match_clr,
    output logic [31:0]      count,
    output logic             match
);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]      count_q, count_d;
    logic             match_q, match_d;
    logic             tick;
    logic             hit;

    assign tick = en && (pre_cnt_q == prescale);
    assign hit  = tick && (count_q == compare);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        count_d   = count_q;
        match_d   = match_q;

        if (prescale_clr || tick) begin
            pre_cnt_d = '0;
        end else if (en) begin
            pre_cnt_d = pre_cnt_q + 1'b1;
        end

        // A bus load overrides whatever the tick would have done this cycle.
        if (count_ld) begin
            count_d = count_ld_val;
        end else if (tick) begin
            count_d = (hit && autoreload) ? 32'h0 : count_q + 32'h1;
        end

        if (match_clr) begin
            match_d = 1'b0;
        end
        if (hit) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt_q <= '0;
            count_q   <= '0;
            match_q   <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            count_q   <= count_d;
            match_q   <= match_d;
        end
    end

    assign count = count_q;
    assign match = match_q;

endmodule

// File: rtl/axil_timer_slave.sv
// AXI4-Lite timer peripheral: register file, write/read channel FSMs, timer_core instance.
// Latency: write response one cycle after both AW and W are held; read data one cycle after AR.
// Backpressure: AW/W stall while a response is pending; AR stalls until the R beat drains.
module axil_timer_slave
    import axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PRE_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [2:0]          s_axi_awprot,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [2:0]          s_axi_arprot,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic                irq
);

    wr_state_e        wr_state_q, wr_state_d;
    logic             aw_held_q, aw_held_d;
    logic [2:0]       awoff_q, awoff_d;
    logic             w_held_q, w_held_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [1:0]       bresp_q, bresp_d;

    rd_state_e        rd_state_q, rd_state_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    logic [2:0]       ctrl_q, ctrl_d;
    logic [31:0]      compare_q, compare_d;
    logic [31:0]      scratch_q, scratch_d;
    logic [PRE_W-1:0] prescale_q, prescale_d;

    logic [31:0]      count;
    logic             match;
    logic             count_ld;
    logic [31:0]      count_ld_val;
    logic             match_clr;
    logic             prescale_clr;

    logic             aw_hs, w_hs, ar_hs;
    logic             wr_commit;
    reg_off_e         wr_off, rd_off;
    logic [31:0]      pre_merged;
    logic [31:0]      rd_val;
    logic             rd_err;
    logic             unused_ok;

    assign s_axi_awready = (wr_state_q == WR_IDLE) && !aw_held_q && !reset;
    assign s_axi_wready  = (wr_state_q == WR_IDLE) && !w_held_q && !reset;
    assign s_axi_bvalid  = (wr_state_q == WR_RESP);
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = (rd_state_q == RD_IDLE) && !reset;
    assign s_axi_rvalid  = (rd_state_q == RD_DATA);
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign irq           = match && ctrl_q[CTRL_IRQ_EN];

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign wr_off = reg_off_e'(awoff_q);
    assign rd_off = reg_off_e'(s_axi_araddr[4:2]);

    assign unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[ADDR_W-1:5], s_axi_awaddr[1:0],
                         s_axi_araddr[ADDR_W-1:5], s_axi_araddr[1:0],
                         pre_merged[31:PRE_W]};

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        awoff_d    = awoff_q;
        w_held_d   = w_held_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awoff_d   = s_axi_awaddr[4:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_axi_wdata;
                    wstrb_d  = s_axi_wstrb;
                end
                if (aw_held_q && w_held_q) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_commit  = 1'b1;
                    wr_state_d = WR_RESP;
                    bresp_d    = (wr_off == REG_RSVD6 || wr_off == REG_RSVD7) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d       = ctrl_q;
        compare_d    = compare_q;
        scratch_d    = scratch_q;
        prescale_d   = prescale_q;
        count_ld     = 1'b0;
        count_ld_val = count;
        match_clr    = 1'b0;
        prescale_clr = 1'b0;
        pre_merged   = merge_bytes(32'(prescale_q), wdata_q, wstrb_q);
        if (wr_commit) begin
            case (wr_off)
                REG_CTRL:     if (wstrb_q[0]) ctrl_d = wdata_q[2:0];
                REG_STATUS:   match_clr = wstrb_q[0] && wdata_q[0];
                REG_COUNT: begin
                    count_ld     = 1'b1;
                    count_ld_val = merge_bytes(count, wdata_q, wstrb_q);
                end
                REG_COMPARE:  compare_d = merge_bytes(compare_q, wdata_q, wstrb_q);
                REG_PRESCALE: begin
                    prescale_d   = pre_merged[PRE_W-1:0];
                    prescale_clr = 1'b1;
                end
                REG_SCRATCH:  scratch_d = merge_bytes(scratch_q, wdata_q, wstrb_q);
                default: ;
            endcase
        end
    end

    // Read data is captured from the pre-edge register values, so a same-cycle write is not visible.
    always_comb begin
        rd_val = 32'h0;
        rd_err = 1'b0;
        case (rd_off)
            REG_CTRL:     rd_val = {29'h0, ctrl_q};
            REG_STATUS:   rd_val = {31'h0, match};
            REG_COUNT:    rd_val = count;
            REG_COMPARE:  rd_val = compare_q;
            REG_PRESCALE: rd_val = 32'(prescale_q);
            REG_SCRATCH:  rd_val = scratch_q;
            default:      rd_err = 1'b1;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rdata_d    = rd_val;
                    rresp_d    = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rd_state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_axi_rready) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            awoff_q    <= '0;
            w_held_q   <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= '0;
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
            rresp_q    <= '0;
            ctrl_q     <= '0;
            compare_q  <= '0;
            scratch_q  <= '0;
            prescale_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            awoff_q    <= awoff_d;
            w_held_q   <= w_held_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            ctrl_q     <= ctrl_d;
            compare_q  <= compare_d;
            scratch_q  <= scratch_d;
            prescale_q <= prescale_d;
        end
    end

    timer_core #(.PRE_W(PRE_W)) u_timer_core (
        .clk          (clk),
        .reset        (reset),
        .en           (ctrl_q[CTRL_EN]),
        .autoreload   (ctrl_q[CTRL_AUTORELOAD]),
        .prescale     (prescale_q),
        .prescale_clr (prescale_clr),
        .compare      (compare_q),
        .count_ld     (count_ld),
        .count_ld_val (count_ld_val),
        .match_clr    (match_clr),
        .count        (count),
        .match        (match)
    );

endmodule

// File: tb/tb_axil_timer_slave.sv
// Scoreboard bench for axil_timer_slave: expected B/R responses queued at issue, checked on arrival.
// Latency: n/a. Backpressure: exercised by holding bready/rready low.
module tb_axil_timer_slave;
    import axil_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        irq;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0]  b_exp_q[$];
    logic [33:0] r_exp_q[$];

    always #5 clk = ~clk;

    axil_timer_slave #(.ADDR_W(32), .DATA_W(32), .PRE_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .irq           (irq)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // w_lead > 0: W leads AW by that many cycles; w_lead < 0: AW leads W.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_lead, input int b_hold, input logic [1:0] exp_resp);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc, aw_start, w_start;
        logic [1:0] exp, resp0;
        b_exp_q.push_back(exp_resp);
        aw_done  = 1'b0;
        w_done   = 1'b0;
        cyc      = 0;
        aw_start = (w_lead > 0) ? w_lead : 0;
        w_start  = (w_lead < 0) ? -w_lead : 0;
        s_axi_awaddr = addr;
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (!aw_done && cyc >= aw_start) s_axi_awvalid = 1'b1;
            if (!w_done && cyc >= w_start)   s_axi_wvalid  = 1'b1;
            aw_fire = s_axi_awvalid && s_axi_awready;
            w_fire  = s_axi_wvalid && s_axi_wready;
            step();
            cyc++;
            if (aw_fire) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
            if (w_fire)  begin w_done  = 1'b1; s_axi_wvalid  = 1'b0; end
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check_eq("aw_w_accept_timeout", {aw_done, w_done}, 2'b11);
            exp = b_exp_q.pop_front();
            return;
        end
        cyc = 0;
        while (!s_axi_bvalid && cyc < 20) begin
            step();
            cyc++;
        end
        if (!s_axi_bvalid) begin
            check_eq("b_timeout", s_axi_bvalid, 1'b1);
            exp = b_exp_q.pop_front();
            return;
        end
        resp0 = s_axi_bresp;
        for (int i = 0; i < b_hold; i++) begin
            step();
            check_eq("b_hold_valid", s_axi_bvalid, 1'b1);
            check_eq("b_hold_resp", s_axi_bresp, resp0);
            check_eq("b_hold_aw_w_ready", {s_axi_awready, s_axi_wready}, 2'b00);
        end
        exp = b_exp_q.pop_front();
        check_eq("bresp", s_axi_bresp, exp);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_hold,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit done;
        int cyc;
        logic [33:0] exp, first;
        r_exp_q.push_back({exp_resp, exp_data});
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 50) begin
            done = s_axi_arready;
            step();
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        if (!done) begin
            check_eq("ar_timeout", done, 1'b1);
            exp = r_exp_q.pop_front();
            return;
        end
        cyc = 0;
        while (!s_axi_rvalid && cyc < 20) begin
            step();
            cyc++;
        end
        if (!s_axi_rvalid) begin
            check_eq("r_timeout", s_axi_rvalid, 1'b1);
            exp = r_exp_q.pop_front();
            return;
        end
        first = {s_axi_rresp, s_axi_rdata};
        for (int i = 0; i < r_hold; i++) begin
            step();
            check_eq("r_hold_valid", s_axi_rvalid, 1'b1);
            check_eq("r_hold_data", {s_axi_rresp, s_axi_rdata}, first);
            check_eq("r_hold_arready", s_axi_arready, 1'b0);
        end
        exp = r_exp_q.pop_front();
        check_eq("rdata", s_axi_rdata, exp[31:0]);
        check_eq("rresp", s_axi_rresp, exp[33:32]);
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
    endtask

    initial begin
        int k;
        reset         = 1'b1;
        s_axi_awaddr  = '0;
        s_axi_awprot  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arprot  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        repeat (3) step();

        check_eq("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        check_eq("rst_valids", {s_axi_bvalid, s_axi_rvalid, irq}, 3'b000);
        check_eq("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, 36'h0);
        reset = 1'b0;
        step();
        check_eq("idle_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        axi_read(32'h00, 0, 32'h0, RESP_OKAY);
        axi_read(32'h10, 0, 32'h0, RESP_OKAY);
        axi_read(32'h08, 0, 32'h0, RESP_OKAY);

        // Register access, byte strobes, channel ordering, address aliasing.
        axi_write(32'h14, 32'hDEAD_BEEF, 4'hF, 1, 0, RESP_OKAY);
        axi_read(32'h14, 0, 32'hDEAD_BEEF, RESP_OKAY);
        axi_write(32'h14, 32'h0000_AB00, 4'b0010, 0, 0, RESP_OKAY);
        axi_read(32'h14, 0, 32'hDEAD_ABEF, RESP_OKAY);
        axi_read(32'hFFFF_FF14, 0, 32'hDEAD_ABEF, RESP_OKAY);
        axi_write(32'h0C, 32'h0000_1234, 4'hF, -2, 0, RESP_OKAY);
        axi_read(32'h0C, 0, 32'h0000_1234, RESP_OKAY);

        // Undecoded slots.
        axi_read(32'h18, 0, 32'h0, RESP_SLVERR);
        axi_write(32'h1C, 32'h5555_5555, 4'hF, 0, 0, RESP_SLVERR);
        axi_read(32'h14, 0, 32'hDEAD_ABEF, RESP_OKAY);
        axi_read(32'h00, 0, 32'h0, RESP_OKAY);

        // Backpressure on B and R.
        axi_write(32'h14, 32'h1122_3344, 4'hF, 0, 5, RESP_OKAY);
        axi_read(32'h14, 5, 32'h1122_3344, RESP_OKAY);

        // Compare match with auto-reload: tick every 4 cycles, match on the third tick.
        axi_write(32'h10, 32'h3, 4'hF, 0, 0, RESP_OKAY);
        axi_write(32'h0C, 32'h2, 4'hF, 0, 0, RESP_OKAY);
        axi_write(32'h00, 32'h7, 4'hF, 0, 0, RESP_OKAY);
        k = 0;
        while (!irq && k < 40) begin
            step();
            k++;
        end
        check_eq("irq_latency", k, 11);
        axi_write(32'h00, 32'h6, 4'hF, 0, 0, RESP_OKAY);
        axi_read(32'h08, 0, 32'h0, RESP_OKAY);
        axi_read(32'h04, 0, 32'h1, RESP_OKAY);
        check_eq("irq_held", irq, 1'b1);
        axi_write(32'h04, 32'h1, 4'hF, 0, 0, RESP_OKAY);
        check_eq("irq_cleared", irq, 1'b0);
        axi_read(32'h04, 0, 32'h0, RESP_OKAY);

        // Wrap without match.
        axi_write(32'h0C, 32'h0000_1000, 4'hF, 0, 0, RESP_OKAY);
        axi_write(32'h10, 32'h0, 4'hF, 0, 0, RESP_OKAY);
        axi_write(32'h08, 32'hFFFF_FFFE, 4'hF, 0, 0, RESP_OKAY);
        axi_write(32'h00, 32'h1, 4'hF, 0, 0, RESP_OKAY);
        step();
        axi_read(32'h08, 0, 32'h0, RESP_OKAY);
        axi_read(32'h04, 0, 32'h0, RESP_OKAY);
        axi_write(32'h00, 32'h0, 4'hF, 0, 0, RESP_OKAY);

        // Reset in the middle of a write: nothing commits, no response appears.
        s_axi_awaddr  = 32'h14;
        s_axi_wdata   = 32'hCAFE_F00D;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        step();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        reset = 1'b1;
        step();
        check_eq("midrst_bvalid", s_axi_bvalid, 1'b0);
        check_eq("midrst_awready", s_axi_awready, 1'b0);
        reset = 1'b0;
        step();
        check_eq("postrst_bvalid", s_axi_bvalid, 1'b0);
        check_eq("postrst_readies", {s_axi_awready, s_axi_wready}, 2'b11);
        axi_read(32'h14, 0, 32'h0, RESP_OKAY);

        check_eq("b_queue_empty", b_exp_q.size(), 0);
        check_eq("r_queue_empty", r_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
